register_write_arbiter: RTL

Round-robin write arbiter that shares one W-bit register (the write-enable/synchronous-clear register) between N requesters. Each requester raises a request with its data. The arbiter drives the register's write enable, synchronous clear and data inputs, and returns a one-cycle acknowledge. It sits between the requesting datapath units and the shared register. A clear request from the control path has priority over all writes.

---
 rtl/register_write_arbiter_if.sv | 42 ++++
 rtl/register_write_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/register_write_arbiter_if.sv
// rtl/register_write_arbiter_if.sv - requester/arbiter bus bundle for the shared register write arbiter
//
// Signals:
//   req              requester -> arbiter  N    per-requester write request (level)
//   req_data         requester -> arbiter  N*W  requester i data on [i*W +: W]
//   clear_req        requester -> arbiter  1    clear request from the control path
//   ack              arbiter -> requester  N    one-hot, one-cycle write acknowledge
//   clear_ack        arbiter -> requester  1    one-cycle clear acknowledge
//   reg_write_enable arbiter -> register   1    shared register write enable
//   reg_clear        arbiter -> register   1    shared register synchronous clear
//   reg_data         arbiter -> register   W    shared register data input
//   grant_id         arbiter -> observer   GW   index of the last granted requester
//   busy             arbiter -> observer   1    high while the arbiter is in ACK
// Modports: master (requesters / control path), slave (arbiter).

interface register_write_arbiter_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int GW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           clear_req;
    logic [N-1:0]   ack;
    logic           clear_ack;
    logic           reg_write_enable;
    logic           reg_clear;
    logic [W-1:0]   reg_data;
    logic [GW-1:0]  grant_id;
    logic           busy;

    modport master (
        output req, req_data, clear_req,
        input  ack, clear_ack, reg_write_enable, reg_clear, reg_data, grant_id, busy
    );

    modport slave (
        input  req, req_data, clear_req,
        output ack, clear_ack, reg_write_enable, reg_clear, reg_data, grant_id, busy
    );
endinterface

// File: rtl/register_write_arbiter.sv
// rtl/register_write_arbiter.sv - round-robin write arbiter sharing one W-bit register between N requesters
//
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      register_write_arbiter_if.slave (requests in; acks, register strobes, grant_id, busy out)
// Build option:
//   REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN - when defined, the lowest-index request wins and no
//   round-robin pointer exists; clear priority and the FSM are unchanged.

module register_write_arbiter #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    register_write_arbiter_if.slave  bus
);
    localparam int GW = $clog2(N);

    typedef enum logic {
        ARB = 1'b0,
        ACK = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_ack;
    logic            r_clear_ack;
    logic            r_reg_write_enable;
    logic            r_reg_clear;
    logic [W-1:0]    r_reg_data;
    logic [GW-1:0]   r_grant_id;
    logic            r_busy;

    state_t          w_state_next;
    logic [N-1:0]    w_ack_next;
    logic            w_clear_ack_next;
    logic            w_reg_write_enable_next;
    logic            w_reg_clear_next;
    logic [W-1:0]    w_reg_data_next;
    logic [GW-1:0]   w_grant_id_next;

    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [W-1:0]    w_win_data;
    int              w_base;
    int              w_sum;

`ifdef REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN
    assign w_base = 0;
`else
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   w_ptr_next;
    logic [GW-1:0]   w_ptr_inc;

    assign w_base    = int'(r_ptr);
    // Explicit wrap keeps this correct for non-power-of-two N.
    assign w_ptr_inc = (w_winner == GW'(N - 1)) ? '0 : w_winner + 1'b1;
`endif

    // Cyclic search starting at w_base; the first set request seen wins.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        w_sum      = 0;
        for (int k = 0; k < N; k++) begin
            w_sum = w_base + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            if (!w_found && bus.req[w_sum]) begin
                w_found    = 1'b1;
                w_winner   = GW'(w_sum);
                w_win_data = bus.req_data[w_sum*W +: W];
            end
        end
    end

    always_comb begin
        w_state_next            = r_state;
        w_ack_next              = '0;
        w_clear_ack_next        = 1'b0;
        w_reg_write_enable_next = 1'b0;
        w_reg_clear_next        = 1'b0;
        w_reg_data_next         = r_reg_data;
        w_grant_id_next         = r_grant_id;
`ifndef REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN
        w_ptr_next              = r_ptr;
`endif
        case (r_state)
            ARB: begin
                // Clear outranks every write and leaves the pointer alone.
                if (bus.clear_req) begin
                    w_reg_clear_next = 1'b1;
                    w_clear_ack_next = 1'b1;
                    w_state_next     = ACK;
                end else if (w_found) begin
                    w_reg_write_enable_next = 1'b1;
                    w_reg_data_next         = w_win_data;
                    w_ack_next[w_winner]    = 1'b1;
                    w_grant_id_next         = w_winner;
`ifndef REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN
                    w_ptr_next              = w_ptr_inc;
`endif
                    w_state_next            = ACK;
                end
            end
            ACK: begin
                // Requests are ignored here so requesters have a cycle to drop req.
                w_state_next = ARB;
            end
            default: begin
                w_state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ARB;
            r_ack              <= '0;
            r_clear_ack        <= 1'b0;
            r_reg_write_enable <= 1'b0;
            r_reg_clear        <= 1'b0;
            r_reg_data         <= '0;
            r_grant_id         <= '0;
            r_busy             <= 1'b0;
`ifndef REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN
            r_ptr              <= '0;
`endif
        end else begin
            r_state            <= w_state_next;
            r_ack              <= w_ack_next;
            r_clear_ack        <= w_clear_ack_next;
            r_reg_write_enable <= w_reg_write_enable_next;
            r_reg_clear        <= w_reg_clear_next;
            r_reg_data         <= w_reg_data_next;
            r_grant_id         <= w_grant_id_next;
            // Registered copy of "next state is ACK" so busy tracks the state with no comb path.
            r_busy             <= (w_state_next == ACK);
`ifndef REGISTER_WRITE_ARBITER_FIXED_PRIORITY_EN
            r_ptr              <= w_ptr_next;
`endif
        end
    end

    assign bus.ack              = r_ack;
    assign bus.clear_ack        = r_clear_ack;
    assign bus.reg_write_enable = r_reg_write_enable;
    assign bus.reg_clear        = r_reg_clear;
    assign bus.reg_data         = r_reg_data;
    assign bus.grant_id         = r_grant_id;
    assign bus.busy             = r_busy;

endmodule
